// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit with MTHI/MTLO write port.
// Optional macro MULT_FAST_EN: single-cycle MULT/MULTU; divides stay iterative.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic                  hi_we,
  input  logic                  lo_we,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic {IDLE, CALC} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [CW-1:0]   r_count;
  logic            r_done;
  logic            r_isDiv;
  logic            r_negRes;
  logic            r_negRem;
  logic            r_divZero;
  logic [DW-1:0]   r_rawA;
  logic [DW-1:0]   r_hi;
  logic [DW-1:0]   r_lo;
  logic [PW-1:0]   r_mulAcc;
  logic [PW-1:0]   r_mulCand;
  logic [DW-1:0]   r_mulPlier;
  logic [DW-1:0]   r_divRem;
  logic [DW-1:0]   r_divQuo;
  logic [DW-1:0]   r_divisor;

  logic            w_signedOp;
  logic            w_negA;
  logic            w_negB;
  logic [DW-1:0]   w_absA;
  logic [DW-1:0]   w_absB;
  logic [PW-1:0]   w_mulAccNext;
  logic [PW-1:0]   w_mulProd;
  logic [PW-1:0]   w_resProd;
  logic [DW:0]     w_divShift;
  logic [DW:0]     w_divDiff;
  logic [DW-1:0]   w_divRemNext;
  logic [DW-1:0]   w_divQuoNext;
  logic [DW-1:0]   w_quo;
  logic [DW-1:0]   w_rem;
  logic            w_fastMul;
  logic            w_finish;

  // Operand magnitudes; signed ops (MULT, DIV) have op[0] clear.
  assign w_signedOp = ~op[0];
  assign w_negA     = w_signedOp & operand_a[DW-1];
  assign w_negB     = w_signedOp & operand_b[DW-1];
  assign w_absA     = w_negA ? -operand_a : operand_a;
  assign w_absB     = w_negB ? -operand_b : operand_b;

  assign w_mulAccNext = r_mulPlier[0] ? (r_mulAcc + r_mulCand) : r_mulAcc;
  assign w_mulProd    = r_negRes ? -w_mulAccNext : w_mulAccNext;

  // Restoring step: the partial remainder stays below the divisor, so DW+1 bits suffice.
  assign w_divShift   = {r_divRem, r_divQuo[DW-1]};
  assign w_divDiff    = w_divShift - {1'b0, r_divisor};
  assign w_divRemNext = w_divDiff[DW] ? w_divShift[DW-1:0] : w_divDiff[DW-1:0];
  assign w_divQuoNext = {r_divQuo[DW-2:0], ~w_divDiff[DW]};

  assign w_quo = r_divZero ? '1     : (r_negRes ? -w_divQuoNext : w_divQuoNext);
  assign w_rem = r_divZero ? r_rawA : (r_negRem ? -w_divRemNext : w_divRemNext);

`ifdef MULT_FAST_EN
  logic [PW-1:0] w_fastMag;
  assign w_fastMag = {{DW{1'b0}}, r_mulCand[DW-1:0]} * {{DW{1'b0}}, r_mulPlier};
  assign w_fastMul = ~r_isDiv;
  assign w_resProd = w_fastMul ? (r_negRes ? -w_fastMag : w_fastMag) : w_mulProd;
`else
  assign w_fastMul = 1'b0;
  assign w_resProd = w_mulProd;
`endif

  assign w_finish = (r_state == CALC) && ((r_count == CW'(DW - 1)) || w_fastMul);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = CALC;
      CALC:    if (w_finish) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == CALC);
    done = r_done;
    hi   = r_hi;
    lo   = r_lo;
  end

  // Datapath: operand capture, iteration, result writeback and MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_done     <= 1'b0;
      r_isDiv    <= 1'b0;
      r_negRes   <= 1'b0;
      r_negRem   <= 1'b0;
      r_divZero  <= 1'b0;
      r_rawA     <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_mulAcc   <= '0;
      r_mulCand  <= '0;
      r_mulPlier <= '0;
      r_divRem   <= '0;
      r_divQuo   <= '0;
      r_divisor  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_count    <= '0;
            r_isDiv    <= op[1];
            r_negRes   <= w_negA ^ w_negB;
            r_negRem   <= op[1] & w_negA;
            r_divZero  <= op[1] & (operand_b == '0);
            r_rawA     <= operand_a;
            r_mulAcc   <= '0;
            r_mulCand  <= {{DW{1'b0}}, w_absA};
            r_mulPlier <= w_absB;
            r_divRem   <= '0;
            r_divQuo   <= w_absA;
            r_divisor  <= w_absB;
          end else begin
            if (hi_we) r_hi <= wr_data;
            if (lo_we) r_lo <= wr_data;
          end
        end
        CALC: begin
          r_count    <= r_count + CW'(1);
          r_mulAcc   <= w_mulAccNext;
          r_mulCand  <= r_mulCand << 1;
          r_mulPlier <= r_mulPlier >> 1;
          r_divRem   <= w_divRemNext;
          r_divQuo   <= w_divQuoNext;
          if (w_finish) begin
            r_done <= 1'b1;
            if (r_isDiv) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end else begin
              r_hi <= w_resProd[PW-1:DW];
              r_lo <= w_resProd[DW-1:0];
            end
          end
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Execute-stage HI/LO arithmetic unit for the MIPS pipeline.
- Consumes register operands and executes MULT, MULTU, DIV and DIVU iteratively, holding results in HI/LO.
- The hazard unit stalls the pipeline on busy.
- Also services MTHI/MTLO writes; HI/LO are read directly by the MFHI/MFLO datapath.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width; only 32 is verified.

Ports:
- clk  input  1  pipeline clock; all state changes on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  launch operation; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- operand_a  input  DATA_WIDTH  rs value: multiplicand or dividend
- operand_b  input  DATA_WIDTH  rt value: multiplier or divisor
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wr_data  input  DATA_WIDTH  MTHI/MTLO data
- busy  output  1  operation in progress; stall request
- done  output  1  one-cycle pulse when HI/LO updated by an operation
- hi  output  DATA_WIDTH  HI register
- lo  output  DATA_WIDTH  LO register

Behaviour:
- Reset values (sync, active-high, overrides everything): state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0.
- States:
  - IDLE: start=1 at edge E0 captures op and operands, then goes to CALC.
  - CALC: runs 32 iterations (counter 0..31), one per cycle.
  - CALC -> IDLE: on the 32nd iteration edge (E32), hi/lo are written and done=1 for exactly one cycle.
- busy: 1 from E0 up to E32, i.e. high for 32 cycles; 0 in IDLE. busy is registered (not combinational from start).
- Multiply:
  - Shift-add on operand magnitudes; signed MULT negates the 64-bit product if the operand signs differ.
  - hi=product[63:32], lo=product[31:0].
- Divide:
  - Restoring shift-subtract on magnitudes; lo=quotient, hi=remainder.
  - Signed DIV: quotient negated if signs differ; remainder takes the dividend's sign.
- Divide by zero (no trap): lo=32'hFFFFFFFF, hi=dividend unchanged.
- DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0.
- start while busy: ignored; no queuing.
- start with hi_we/lo_we in the same IDLE cycle: start wins; writes are dropped.
- hi_we/lo_we:
  - In IDLE, write wr_data to hi/lo at the next edge; both may be asserted together.
  - While busy, ignored.
- Operands are captured at E0; input changes afterwards have no effect.
- hi/lo hold their values throughout CALC and change only at E32 or on MTHI/MTLO/reset.
- Reset mid-operation: aborts at that edge; busy=0, done=0, hi=lo=0 next cycle.
- Back-to-back: start may be asserted in the done cycle (state is IDLE); the new operation begins at that edge.

Optional Feature:
- Macro MULT_FAST_EN.
- Defined:
  - MULT/MULTU use a single-cycle 32x32 multiplier.
  - busy is high for 1 cycle; hi/lo are written and done pulses at E1.
  - DIV/DIVU unchanged, 32 cycles.
- Undefined: all operations use the 32-cycle iterative path described above.

Test Plan:
- Reset, then MULTU a=32'hFFFFFFFF b=32'hFFFFFFFF -> busy 32 cycles; done pulse; hi=32'hFFFFFFFE, lo=32'h00000001.
- MULT a=-3 (32'hFFFFFFFD) b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- DIV a=-7 b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
- DIVU a=100 b=0 -> lo=32'hFFFFFFFF, hi=100.
- DIV a=32'h80000000 b=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- MTHI wr_data=32'h1234 in IDLE -> hi=32'h1234 next cycle.
- During the same run:
  - A second start mid-operation -> ignored.
  - hi_we while busy -> ignored.
  - reset asserted at iteration 10 -> busy=0, hi=lo=0, no done pulse.
